// File: rtl/softusb_io_uart.sv
// softusb_io_uart: IO-bus 8N1 UART for the navre core.
// TX through a small FIFO, RX into a single holding register.
module softusb_io_uart #(
    parameter logic [5:0]  BASE      = 6'h20,
    parameter logic [15:0] DIV_RESET = 16'd434,
    parameter int          TXD_LOG2  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [5:0] io_a,
    input  logic [7:0] io_wdat,
    output logic [7:0] io_rdat,
    output logic       irq,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int DEPTH = 1 << TXD_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [5:0]  off;
    logic        hit;
    logic        wr_data, wr_stat, wr_dlo, wr_dhi, rd_data;
    logic [15:0] div, div_eff, half_eff;

    logic [7:0]          fifo [DEPTH];
    logic [TXD_LOG2-1:0] wr_ptr, rd_ptr;
    logic [TXD_LOG2:0]   tx_cnt_q;
    logic                tx_full, tx_empty, push_ok;

    state_t      tx_state, tx_state_n;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_pop, tx_reload, tx_step, tx_n, tx_done;

    state_t      rx_state, rx_state_n;
    logic        rx_s1, rx_s2, rx_d;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_hold;
    logic        rx_rl_half, rx_rl_full, rx_sample, rx_ok, rx_bad, rx_done;

    logic rx_avail, rx_overrun, rx_frame_err, tx_overflow;
    logic [7:0] stat, rmux;

    // Subtracting first makes the 4-entry window decode wrap-safe.
    assign off     = io_a - BASE;
    assign hit     = (off[5:2] == 4'd0);
    assign wr_data = io_we & hit & (off[1:0] == 2'd0);
    assign wr_stat = io_we & hit & (off[1:0] == 2'd1);
    assign wr_dlo  = io_we & hit & (off[1:0] == 2'd2);
    assign wr_dhi  = io_we & hit & (off[1:0] == 2'd3);
    assign rd_data = io_re & hit & (off[1:0] == 2'd0);

    assign div_eff  = (div == 16'd0) ? 16'd1 : div;
    assign half_eff = (div_eff[15:1] == 15'd0) ? 16'd1 : {1'b0, div_eff[15:1]};

    assign tx_full  = (tx_cnt_q == (TXD_LOG2+1)'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign push_ok  = wr_data & (~tx_full | tx_pop);
    assign tx_done  = (tx_cnt <= 16'd1);
    assign rx_done  = (rx_cnt <= 16'd1);
    assign irq      = rx_avail;

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[wr_ptr] <= io_wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok & ~tx_pop)
                tx_cnt_q <= tx_cnt_q + 1'b1;
            else if (tx_pop & ~push_ok)
                tx_cnt_q <= tx_cnt_q - 1'b1;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_reload  = 1'b0;
        tx_step    = 1'b0;
        tx_n       = uart_tx;
        unique case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_reload  = 1'b1;
                tx_n       = 1'b0;
                tx_state_n = S_START;
            end
            S_START: if (tx_done) begin
                tx_reload  = 1'b1;
                tx_n       = tx_shift[0];
                tx_state_n = S_DATA;
            end
            S_DATA: if (tx_done) begin
                tx_reload = 1'b1;
                if (tx_bit == 3'd7) begin
                    tx_n       = 1'b1;
                    tx_state_n = S_STOP;
                end else begin
                    tx_step = 1'b1;
                    tx_n    = tx_shift[1];
                end
            end
            S_STOP: if (tx_done) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_reload  = 1'b1;
                    tx_n       = 1'b0;
                    tx_state_n = S_START;
                end else begin
                    tx_state_n = S_IDLE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            uart_tx  <= tx_n;
            if (tx_reload)
                tx_cnt <= div_eff;
            else if (tx_cnt > 16'd1)
                tx_cnt <= tx_cnt - 16'd1;
            if (tx_pop) begin
                tx_shift <= fifo[rd_ptr];
                tx_bit   <= 3'd0;
            end else if (tx_step) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_rl_half = 1'b0;
        rx_rl_full = 1'b0;
        rx_sample  = 1'b0;
        rx_ok      = 1'b0;
        rx_bad     = 1'b0;
        unique case (rx_state)
            S_IDLE: if (rx_d & ~rx_s2) begin
                rx_rl_half = 1'b1;
                rx_state_n = S_START;
            end
            S_START: if (rx_done) begin
                if (!rx_s2) begin
                    rx_rl_full = 1'b1;
                    rx_state_n = S_DATA;
                end else begin
                    rx_state_n = S_IDLE;
                end
            end
            S_DATA: if (rx_done) begin
                rx_sample  = 1'b1;
                rx_rl_full = 1'b1;
                if (rx_bit == 3'd7)
                    rx_state_n = S_STOP;
            end
            S_STOP: if (rx_done) begin
                rx_ok      = rx_s2;
                rx_bad     = ~rx_s2;
                rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_state_n;
            if (rx_rl_half)
                rx_cnt <= half_eff;
            else if (rx_rl_full)
                rx_cnt <= div_eff;
            else if (rx_cnt > 16'd1)
                rx_cnt <= rx_cnt - 16'd1;
            if (rx_rl_half)
                rx_bit <= 3'd0;
            else if (rx_sample)
                rx_bit <= rx_bit + 3'd1;
            if (rx_sample)
                rx_shift <= {rx_s2, rx_shift[7:1]};
        end
    end

    // A DATA read on the stop edge frees the holder for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold      <= 8'd0;
            rx_avail     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            div          <= DIV_RESET;
        end else begin
            if (rx_ok & (~rx_avail | rd_data)) begin
                rx_hold  <= rx_shift;
                rx_avail <= 1'b1;
            end else if (rd_data) begin
                rx_avail <= 1'b0;
            end
            if (rx_ok & rx_avail & ~rd_data)
                rx_overrun <= 1'b1;
            else if (wr_stat & io_wdat[3])
                rx_overrun <= 1'b0;
            if (wr_data & tx_full & ~tx_pop)
                tx_overflow <= 1'b1;
            else if (wr_stat & io_wdat[4])
                tx_overflow <= 1'b0;
            if (rx_bad)
                rx_frame_err <= 1'b1;
            else if (wr_stat & io_wdat[5])
                rx_frame_err <= 1'b0;
            if (wr_dlo)
                div[7:0] <= io_wdat;
            if (wr_dhi)
                div[15:8] <= io_wdat;
        end
    end

    assign stat = {2'b00, rx_frame_err, tx_overflow, rx_overrun, rx_avail,
                   tx_empty & (tx_state == S_IDLE), tx_full};

    always_comb begin
        rmux = 8'd0;
        unique case (off[1:0])
            2'd0: rmux = rx_hold;
            2'd1: rmux = stat;
            2'd2: rmux = div[7:0];
            2'd3: rmux = div[15:8];
            default: rmux = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            io_rdat <= 8'd0;
        else
            io_rdat <= (io_re & hit) ? rmux : 8'd0;
    end

endmodule

// File: tb/tb_softusb_io_uart.sv
// tb_softusb_io_uart: randomized scoreboard bench for softusb_io_uart.
// Read data and serial TX frames are checked by independent monitors.
module tb_softusb_io_uart;

    localparam logic [5:0] BASE = 6'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       io_re = 1'b0;
    logic       io_we = 1'b0;
    logic [5:0] io_a = 6'd0;
    logic [7:0] io_wdat = 8'd0;
    logic [7:0] io_rdat;
    logic       irq;
    logic       uart_rx = 1'b1;
    logic       uart_tx;

    softusb_io_uart #(.BASE(BASE), .DIV_RESET(16'd434), .TXD_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .io_re(io_re), .io_we(io_we),
        .io_a(io_a), .io_wdat(io_wdat), .io_rdat(io_rdat), .irq(irq),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cur_div = 434;
    bit mon_en = 1'b0;
    bit tx_abort = 1'b0;
    bit re_d = 1'b0;

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    int         starts [$];

    bit         m_avail, m_ovr, m_ferr, m_txovf, m_have;
    logic [7:0] m_hold;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] stat_exp();
        return {2'b00, m_ferr, m_txovf, m_ovr, m_avail, 1'b1, 1'b0};
    endfunction

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        re_d <= io_re;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (re_d) begin
                    if (rd_q.size() == 0)
                        chk("rd unexpected", 1, 0);
                    else
                        chk("rd data", io_rdat, rd_q.pop_front());
                end else begin
                    chk("rdat idle", io_rdat, 0);
                end
            end
        end
    end

    initial begin
        logic prev, st, sp;
        logic [7:0] b, e;
        int d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_tx) begin
                starts.push_back(cyc);
                d = cur_div;
                repeat (d / 2) @(negedge clk);
                st = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (d) @(negedge clk);
                sp = uart_tx;
                if (tx_abort) begin
                    if (tx_q.size() != 0) void'(tx_q.pop_front());
                end else if (tx_q.size() == 0) begin
                    chk("tx unexpected frame", 1, 0);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx byte", b, e);
                    chk("tx start/stop", {st, sp}, 2'b01);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wr_a(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        io_we = 1'b1; io_a = a; io_wdat = d;
        @(posedge clk); #1;
        io_we = 1'b0;
    endtask

    task automatic rd_a(input logic [5:0] a, input logic [7:0] e);
        @(posedge clk); #1;
        io_re = 1'b1; io_a = a;
        rd_q.push_back(e);
        @(posedge clk); #1;
        io_re = 1'b0;
    endtask

    task automatic set_div(input int v);
        logic [15:0] w;
        w = 16'(v);
        wr_a(BASE + 6'd2, w[7:0]);
        wr_a(BASE + 6'd3, w[15:8]);
        cur_div = v;
    endtask

    task automatic tx_send(input logic [7:0] b);
        tx_q.push_back(b);
        wr_a(BASE, b);
    endtask

    task automatic rd_dat();
        rd_a(BASE, m_hold);
        m_avail = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (cur_div) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (cur_div) @(posedge clk);
        end
        #1 uart_rx = stop;
        repeat (cur_div) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (cur_div + 4) @(posedge clk);
        if (!stop) begin
            m_ferr = 1'b1;
        end else if (!m_avail) begin
            m_hold = b; m_avail = 1'b1; m_have = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic rx_glitch();
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (2 * cur_div + 4) @(posedge clk);
    endtask

    initial begin
        int idx0, n, op;
        logic [7:0] b, v;
        m_avail = 0; m_ovr = 0; m_ferr = 0; m_txovf = 0; m_have = 0;
        m_hold = 8'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset uart_tx", uart_tx, 1);
        chk("reset irq", irq, 0);
        chk("reset io_rdat", io_rdat, 0);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;
        rd_a(BASE + 6'd1, 8'h02);
        rd_a(BASE + 6'd2, 8'hB2);
        rd_a(BASE + 6'd3, 8'h01);

        set_div(4);
        tx_send(8'hA5);
        @(negedge clk);
        chk("tx latency edge1", uart_tx, 1);
        @(negedge clk);
        chk("tx latency edge2", uart_tx, 0);
        repeat (48) @(posedge clk);
        rd_a(BASE + 6'd1, stat_exp());

        idx0 = starts.size();
        for (int i = 0; i < 5; i++)
            tx_send(8'($urandom));
        wr_a(BASE, 8'($urandom));
        m_txovf = 1'b1;
        rd_a(BASE + 6'd1, {2'b00, m_ferr, 1'b1, m_ovr, m_avail, 1'b0, 1'b1});
        wr_a(BASE + 6'd1, 8'h10);
        m_txovf = 1'b0;
        rd_a(BASE + 6'd1, {2'b00, m_ferr, 1'b0, m_ovr, m_avail, 1'b0, 1'b1});
        repeat (5 * 40 + 10) @(posedge clk);
        rd_a(BASE + 6'd1, stat_exp());
        if (starts.size() < idx0 + 5) begin
            chk("tx burst frame count", starts.size() - idx0, 5);
        end else begin
            for (int i = 1; i < 5; i++)
                chk("tx burst gap", starts[idx0+i] - starts[idx0+i-1], 40);
        end

        for (int r = 0; r < 3; r++) begin
            set_div($urandom_range(3, 8));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                tx_send(8'($urandom));
            repeat (n * 10 * cur_div + 10) @(posedge clk);
            rd_a(BASE + 6'd1, stat_exp());
        end

        set_div(4);
        rx_frame(8'h3C, 1'b1);
        @(negedge clk);
        chk("rx irq set", irq, 1);
        rd_a(BASE + 6'd1, stat_exp());
        rd_dat();
        @(negedge clk);
        chk("rx irq clear", irq, 0);

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        rd_a(BASE + 6'd1, stat_exp());
        rd_dat();
        rx_frame(8'h5E, 1'b1);
        rx_frame(8'h77, 1'b0);
        rd_a(BASE + 6'd1, stat_exp());
        wr_a(BASE + 6'd1, 8'h28);
        m_ovr = 0; m_ferr = 0;
        rd_a(BASE + 6'd1, stat_exp());

        for (int r = 0; r < 16; r++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: rx_frame(8'($urandom), 1'b1);
                2: rx_frame(8'($urandom), 1'b0);
                3: if (m_have) rd_dat();
                4: begin
                    rd_a(BASE + 6'd1, stat_exp());
                    v = 8'($urandom);
                    wr_a(BASE + 6'd1, v);
                    if (v[3]) m_ovr = 1'b0;
                    if (v[4]) m_txovf = 1'b0;
                    if (v[5]) m_ferr = 1'b0;
                    set_div($urandom_range(4, 9));
                end
                default: rx_glitch();
            endcase
            @(negedge clk);
            chk("irq vs model", irq, m_avail);
        end
        rd_a(BASE + 6'd1, stat_exp());

        rd_a(BASE + 6'd4, 8'h00);
        rd_a(BASE - 6'd1, 8'h00);
        wr_a(BASE + 6'd6, 8'h55);
        set_div(8);
        rd_a(BASE + 6'd2, 8'h08);
        rd_a(BASE + 6'd3, 8'h00);
        b = 8'($urandom);
        tx_send(b);
        repeat (10 * 8 + 10) @(posedge clk);
        rd_a(BASE + 6'd1, stat_exp());

        set_div(4);
        tx_send(8'h00);
        repeat (12) @(posedge clk);
        #1 chk("tx low before reset", uart_tx, 0);
        @(posedge clk); #2;
        tx_abort = 1'b1;
        rst_n = 1'b0;
        #1 chk("async reset uart_tx", uart_tx, 1);
        chk("async reset irq", irq, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_avail = 0; m_ovr = 0; m_ferr = 0; m_txovf = 0;
        cur_div = 434;
        repeat (50) @(posedge clk);
        rd_a(BASE + 6'd1, 8'h02);
        rd_a(BASE + 6'd2, 8'hB2);
        @(negedge clk);
        chk("uart_tx idle after reset", uart_tx, 1);

        repeat (5) @(posedge clk);
        chk("tx queue drained", tx_q.size(), 0);
        chk("rd queue drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
